// File: rtl/range_merger_pkg.sv
// range_merger_pkg: shared range type, default widths and merger states
package range_merger_pkg;
  localparam int VAL_WIDTH_DEF = 64;
  localparam int TOTAL_WIDTH_DEF = 72;
  typedef struct packed {
    logic [VAL_WIDTH_DEF-1:0] lo;
    logic [VAL_WIDTH_DEF-1:0] hi;
  } tuple_pair_t;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
endpackage

// File: rtl/range_merger_len.sv
// range_len: inclusive length hi-lo+1 of a range, widened to TOTAL_WIDTH
module range_len
  import range_merger_pkg::*;
#(
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  tuple_pair_t            pair,
  output logic [TOTAL_WIDTH-1:0] len
);
  assign len = TOTAL_WIDTH'(pair.hi) - TOTAL_WIDTH'(pair.lo) + TOTAL_WIDTH'(1);
endmodule

// File: rtl/range_merger.sv
// range_merger: merges a lo-sorted stream of inclusive ranges into disjoint ranges.
// RANGE_MERGER_TOTAL_EN builds the covered-ID accumulator behind total_out.
module range_merger
  import range_merger_pkg::*;
#(
  parameter int VAL_WIDTH = VAL_WIDTH_DEF,
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  tuple_pair_t            pair_in,
  input  logic                   last_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output tuple_pair_t            pair_out,
  output logic                   last_out,
  output logic                   done_out,
  output logic [TOTAL_WIDTH-1:0] total_out
);
  state_t state, state_n;
  tuple_pair_t cur, cur_n, out_n;
  logic load, out_last, done_set, accept, bad, merge, out_free;
  assign out_free = !valid_out || ready_out;
  assign ready_in = !reset && (state == IDLE || state == ACCUM) && out_free;
  assign accept = valid_in && ready_in;
  assign bad = pair_in.lo > pair_in.hi;
  // one extra bit so cur.hi = all-ones plus one does not wrap to zero
  assign merge = (VAL_WIDTH+1)'(pair_in.lo) <= (VAL_WIDTH+1)'(cur.hi) + (VAL_WIDTH+1)'(1);
  always_ff @(posedge clock) begin
    state <= reset ? IDLE : state_n;
    cur <= reset ? '0 : cur_n;
  end
  always_comb begin
    state_n = state;
    cur_n = cur;
    load = 1'b0;
    out_n = cur;
    out_last = 1'b0;
    done_set = valid_out && ready_out && last_out;
    case (state)
      IDLE:
        if (accept) begin
          cur_n = bad ? cur : pair_in;
          state_n = bad ? (last_in ? DONE : IDLE) : (last_in ? FLUSH : ACCUM);
          done_set = done_set || (bad && last_in);
        end
      ACCUM:
        if (accept) begin
          if (!bad && merge) cur_n.hi = pair_in.hi > cur.hi ? pair_in.hi : cur.hi;
          if (!bad && !merge) cur_n = pair_in;
          load = !bad && !merge;
          state_n = last_in ? FLUSH : ACCUM;
        end
      FLUSH:
        if (out_free) begin
          load = 1'b1;
          out_last = 1'b1;
          state_n = DONE;
        end
      DONE: state_n = DONE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      last_out <= 1'b0;
      pair_out <= '0;
      done_out <= 1'b0;
    end else begin
      if (load) begin
        valid_out <= 1'b1;
        pair_out <= out_n;
        last_out <= out_last;
      end else if (ready_out) valid_out <= 1'b0;
      if (done_set) done_out <= 1'b1;
    end
  end
`ifdef RANGE_MERGER_TOTAL_EN
  logic [TOTAL_WIDTH-1:0] len;
  range_len #(.TOTAL_WIDTH(TOTAL_WIDTH)) u_len (.pair(out_n), .len(len));
  always_ff @(posedge clock) total_out <= reset ? '0 : (load ? total_out + len : total_out);
`else
  assign total_out = '0;
`endif
endmodule

// File: tb/tb_range_merger.sv
// tb_range_merger: directed streams with a queue scoreboard checking every output beat
module tb_range_merger;
  import range_merger_pkg::*;
`ifdef RANGE_MERGER_TOTAL_EN
  localparam bit TOT = 1'b1;
`else
  localparam bit TOT = 1'b0;
`endif
  localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clock = 0, reset = 1, valid_in = 0, last_in = 0, ready_out = 1;
  logic ready_in, valid_out, last_out, done_out;
  tuple_pair_t pair_in = '0, pair_out;
  logic [71:0] total_out;
  logic [128:0] q[$];
  int n_chk = 0, n_fail = 0;

  range_merger dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .pair_in(pair_in), .last_in(last_in), .valid_out(valid_out), .ready_out(ready_out),
    .pair_out(pair_out), .last_out(last_out), .done_out(done_out), .total_out(total_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && valid_out && ready_out) begin
      if (q.size() == 0) chk("unexpected_beat", {pair_out, last_out}, '0);
      else chk("beat", {pair_out, last_out}, q.pop_front());
    end
  end

  task automatic expect_beat(input logic [63:0] lo, input logic [63:0] hi, input logic last);
    q.push_back({lo, hi, last});
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; valid_in = 0;
    @(negedge clock);
    chk("ready_in_in_reset", 129'(ready_in), 129'(0));
    @(posedge clock); #1;
    chk("valid_out_rst", 129'(valid_out), 129'(0));
    chk("last_out_rst", 129'(last_out), 129'(0));
    chk("done_out_rst", 129'(done_out), 129'(0));
    chk("pair_out_rst", 129'(pair_out), 129'(0));
    chk("total_out_rst", 129'(total_out), 129'(0));
    reset = 0;
  endtask

  task automatic send(input logic [63:0] lo, input logic [63:0] hi, input logic last);
    int n = 0;
    pair_in = '{lo: lo, hi: hi};
    last_in = last;
    valid_in = 1;
    @(negedge clock);
    while (!ready_in && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready_in) chk("send_timeout", 129'(ready_in), 129'(1));
    @(posedge clock); #1;
    valid_in = 0;
  endtask

  task automatic finish_test(input string nm, input logic [71:0] tot);
    int n = 0;
    while (!done_out && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_done"}, 129'(done_out), 129'(1));
    chk({nm, "_total"}, 129'(total_out), 129'(TOT ? tot : 72'd0));
    chk({nm, "_drained"}, 129'(q.size()), 129'(0));
  endtask

  initial begin
    do_reset();
    expect_beat(3, 5, 0); expect_beat(10, 20, 1);
    send(3, 5, 0); send(10, 14, 0); send(12, 18, 0); send(16, 20, 1);
    finish_test("overlap", 14);

    do_reset();
    expect_beat(1, 9, 1);
    send(1, 4, 0); send(5, 9, 1);
    finish_test("adjacent", 9);

    do_reset();
    expect_beat(7, 7, 1);
    send(7, 7, 1);
    finish_test("single", 1);

    do_reset();
    ready_out = 0;
    expect_beat(0, 2, 0); expect_beat(10, 11, 0); expect_beat(20, 21, 1);
    fork
      begin
        send(0, 2, 0); send(10, 11, 0); send(20, 21, 1);
      end
      begin
        int n = 0;
        while (!valid_out && n < 50) begin
          @(negedge clock);
          n++;
        end
        chk("stall_valid", 129'(valid_out), 129'(1));
        repeat (5) begin
          @(negedge clock);
          chk("stall_hold", 129'(pair_out), {65'd0, 64'd2});
          chk("stall_ready_in", 129'(ready_in), 129'(0));
        end
        @(posedge clock); #1;
        ready_out = 1;
      end
    join
    finish_test("stall", 7);

    do_reset();
    expect_beat(3, MAX, 1);
    send(3, MAX, 0); send(5, 6, 1);
    finish_test("no_wrap", 72'h00_FFFF_FFFF_FFFF_FFFD);

    do_reset();
    expect_beat(2, 6, 1);
    send(2, 4, 0); send(9, 3, 0); send(5, 6, 1);
    finish_test("bad_mid", 5);

    do_reset();
    expect_beat(2, 4, 1);
    send(2, 4, 0); send(8, 1, 1);
    finish_test("bad_last", 3);

    do_reset();
    ready_out = 0;
    send(1, 2, 0); send(10, 11, 0);
    do_reset();
    ready_out = 1;
    expect_beat(1, 1, 1);
    send(1, 1, 1);
    finish_test("reset_mid", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
